// File: rtl/line_buf_pkg.sv
// line_buf_pkg
//   Types and default constants shared by the line buffer read controller
//   and by users of fifo_line_buf.
//   lb_state_t      : read controller FSM state encoding
//   LB_DATA_WIDTH   : default pixel / FIFO read width
//   LB_LINE_PIXELS  : default pixels per line request
package line_buf_pkg;

   localparam int LB_DATA_WIDTH  = 8;
   localparam int LB_LINE_PIXELS = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } lb_state_t;

endpackage

// File: rtl/line_buf_rd_ctrl.sv
// line_buf_rd_ctrl
//   Reads one line of LINE_PIXELS pixels from a line buffer FIFO per
//   line_req pulse and emits it as a pixel stream with start/end-of-line
//   markers, two cycles behind the FIFO read strobe.
//
//   Build option: define LINE_BUF_RD_PAD_EN to replace FIFO underflow
//   cycles with PAD_VALUE pixels (gap-free line). Without it, underflow
//   cycles leave gaps and the line is stretched until all pixels arrive.
//
//   Ports
//   rd_clk             in   clock (FIFO read side)
//   rd_rst_n           in   async active-low reset
//   line_req           in   one-cycle pulse, request one line
//   fifo_rd_data       in   FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_empty      in   FIFO empty
//   fifo_almost_empty  in   FIFO almost empty
//   fifo_rd_en         out  FIFO read strobe
//   pix_data           out  pixel
//   pix_valid          out  pixel qualifier
//   pix_sol / pix_eol  out  first / last pixel of a line
//   busy               out  state != IDLE
//   underflow          out  sticky: READ cycle with FIFO empty
//   req_drop           out  sticky: line_req ignored while busy
//
//   state | meaning
//   IDLE  | waiting for line_req
//   WAIT  | line requested, waiting for FIFO to leave almost-empty
//   READ  | reading pixels until LINE_PIXELS counted
//   DRAIN | two cycles letting the output pipeline empty
module line_buf_rd_ctrl
   import line_buf_pkg::*;
#(
   parameter int                    DATA_WIDTH  = LB_DATA_WIDTH,
   parameter int                    LINE_PIXELS = LB_LINE_PIXELS,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  line_req,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_empty,
   input  logic                  fifo_almost_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_valid,
   output logic                  pix_sol,
   output logic                  pix_eol,
   output logic                  busy,
   output logic                  underflow,
   output logic                  req_drop
);

   localparam int            CW       = $clog2(LINE_PIXELS) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(LINE_PIXELS - 1);

   lb_state_t     state, state_nx;
   logic [CW-1:0] pix_cnt;
   logic          drain_cnt;
   logic          count_en;
   logic          last_pix;

   logic          s1_valid;
   logic          s1_rd;
   logic          s1_sol;
   logic          s1_eol;

   always_comb begin
      state_nx   = state;
      fifo_rd_en = 1'b0;
      count_en   = 1'b0;
      last_pix   = 1'b0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (line_req) state_nx = WAIT;
         end
         WAIT: begin
            if (!fifo_almost_empty) state_nx = READ;
         end
         READ: begin
            fifo_rd_en = !fifo_rd_empty;
`ifdef LINE_BUF_RD_PAD_EN
            count_en   = 1'b1;
`else
            count_en   = !fifo_rd_empty;
`endif
            last_pix   = count_en && (pix_cnt == LAST_IDX);
            if (last_pix) state_nx = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state     <= IDLE;
         pix_cnt   <= '0;
         drain_cnt <= 1'b0;
         underflow <= 1'b0;
         req_drop  <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state != READ) && (state_nx == READ))
            pix_cnt <= '0;
         else if (count_en)
            pix_cnt <= pix_cnt + CW'(1);
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         if ((state == READ) && fifo_rd_empty)
            underflow <= 1'b1;
         if (line_req && (state != IDLE))
            req_drop <= 1'b1;
      end
   end

   // Stage 1 tracks the cycle in which the FIFO presents the read data;
   // stage 2 registers it onto the pixel outputs.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         s1_valid  <= 1'b0;
         s1_rd     <= 1'b0;
         s1_sol    <= 1'b0;
         s1_eol    <= 1'b0;
         pix_valid <= 1'b0;
         pix_sol   <= 1'b0;
         pix_eol   <= 1'b0;
         pix_data  <= '0;
      end else begin
         s1_valid  <= count_en;
         s1_rd     <= fifo_rd_en;
         s1_sol    <= count_en && (pix_cnt == '0);
         s1_eol    <= last_pix;
         pix_valid <= s1_valid;
         pix_sol   <= s1_valid && s1_sol;
         pix_eol   <= s1_valid && s1_eol;
         // A counted pixel without a read only exists when padding is built in.
         if (s1_rd)
            pix_data <= fifo_rd_data;
         else if (s1_valid)
            pix_data <= PAD_VALUE;
      end
   end

endmodule

// File: tb/tb_line_buf_rd_ctrl.sv
// tb_line_buf_rd_ctrl
//   Self-checking bench for line_buf_rd_ctrl with LINE_PIXELS=16 and a
//   behavioural FIFO. Expected pixels are queued when a line is set up and
//   compared as the DUT emits them. Honours LINE_BUF_RD_PAD_EN.
module tb_line_buf_rd_ctrl;

   localparam int         LP  = 16;
   localparam logic [7:0] PAD = 8'hA5;
`ifdef LINE_BUF_RD_PAD_EN
   localparam bit PAD_MODE = 1'b1;
`else
   localparam bit PAD_MODE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rd_rst_n;
   logic       line_req;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       fifo_rd_empty;
   logic       fifo_almost_empty;
   logic       fifo_rd_en;
   logic [7:0] pix_data;
   logic       pix_valid, pix_sol, pix_eol, busy, underflow, req_drop;

   line_buf_rd_ctrl #(.DATA_WIDTH(8), .LINE_PIXELS(LP), .PAD_VALUE(PAD)) dut (
      .rd_clk(clk), .rd_rst_n(rd_rst_n), .line_req(line_req),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
      .fifo_almost_empty(fifo_almost_empty), .fifo_rd_en(fifo_rd_en),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_sol(pix_sol),
      .pix_eol(pix_eol), .busy(busy), .underflow(underflow), .req_drop(req_drop)
   );

   always #5 clk = ~clk;

   // behavioural FIFO, data valid the cycle after the read strobe
   logic [7:0] mem [64];
   int         rd_ptr = 0;
   int         wr_ptr = 0;
   logic       clr = 1'b0;
   logic       stall = 1'b0;

   assign fifo_rd_empty = stall || (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (clr) rd_ptr <= 0;
      else if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   typedef struct packed {
      logic [7:0] d;
      logic       sol;
      logic       eol;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0] first;
      int         ae;
      int         stall_at;
      int         stall_len;
      int         drop_at;
      logic       exp_uf;
      logic       exp_rd;
      int         exp_gap;
   } row_t;
   row_t rows[4];

   int   checks = 0, errors = 0;
   int   rd_cnt, valid_cnt, gap_run, max_gap, bad_rd;
   int   stall_left, stall_at, stall_len;
   logic stall_armed = 1'b0;
   logic eol_now;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance one cycle: update the empty-stall schedule just after the edge,
   // then sample outputs and run the scoreboard.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (stall) begin
         stall_left--;
         if (stall_left == 0) stall = 1'b0;
      end else if (stall_armed && rd_cnt == stall_at) begin
         stall       = 1'b1;
         stall_left  = stall_len;
         stall_armed = 1'b0;
      end
      #1;
      eol_now = 1'b0;
      if (fifo_rd_en) begin
         rd_cnt++;
         if (fifo_rd_empty) bad_rd++;
      end
      if (pix_valid) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_extra actual=%0h required=none", pix_data);
         end else begin
            e = sb.pop_front();
            check($sformatf("pixel%0d{data,sol,eol}", valid_cnt),
                  32'({pix_data, pix_sol, pix_eol}), 32'({e.d, e.sol, e.eol}));
         end
         if (gap_run > max_gap) max_gap = gap_run;
         gap_run = 0;
         valid_cnt++;
         eol_now = pix_eol;
      end else if (valid_cnt > 0 && valid_cnt < LP) begin
         gap_run++;
      end
   endtask

   task automatic preload(input logic [7:0] first);
      wr_ptr = 0;
      clr    = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 8'(first - 8'(i));
      wr_ptr = 32;
   endtask

   task automatic start_line(input row_t r);
      int   fi;
      logic ae_bad;
      exp_t e;
      preload(r.first);
      fi = 0;
      for (int k = 0; k < LP; k++) begin
         if (PAD_MODE && r.stall_len > 0 && k >= r.stall_at && k < r.stall_at + r.stall_len)
            e.d = PAD;
         else begin
            e.d = 8'(r.first - 8'(fi));
            fi++;
         end
         e.sol = (k == 0);
         e.eol = (k == LP - 1);
         sb.push_back(e);
      end
      rd_cnt = 0; valid_cnt = 0; gap_run = 0; max_gap = 0; bad_rd = 0;
      stall_at = r.stall_at; stall_len = r.stall_len; stall_armed = (r.stall_len > 0);
      fifo_almost_empty = (r.ae > 0);
      line_req = 1'b1;
      step();
      line_req = 1'b0;
      if (r.ae > 0) begin
         ae_bad = 1'b0;
         for (int i = 0; i < r.ae; i++) begin
            if (!busy || fifo_rd_en) ae_bad = 1'b1;
            step();
         end
         check("almost_empty_hold_busy1_rden0", 32'(ae_bad), 32'd0);
         check("almost_empty_no_reads", 32'(rd_cnt), 32'd0);
         fifo_almost_empty = 1'b0;
      end
   endtask

   task automatic run_line(input row_t r);
      logic done, dropped;
      start_line(r);
      done = 1'b0; dropped = 1'b0;
      for (int g = 0; g < 100 && !done; g++) begin
         line_req = 1'b0;
         if (r.drop_at >= 0 && rd_cnt == r.drop_at && !dropped) begin
            line_req = 1'b1;
            dropped  = 1'b1;
         end
         step();
         line_req = 1'b0;
         if (eol_now) begin
            check("busy_at_eol", 32'(busy), 32'd1);
            step();
            check("busy_after_drain", 32'(busy), 32'd0);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL line_timeout actual=no_eol required=eol valid_cnt=%0d", valid_cnt);
      end
      check("valid_count", 32'(valid_cnt), 32'(LP));
      check("max_gap", 32'(max_gap), 32'(r.exp_gap));
      check("sb_leftover", 32'(sb.size()), 32'd0);
      check("underflow", 32'(underflow), 32'(r.exp_uf));
      check("req_drop", 32'(req_drop), 32'(r.exp_rd));
      check("read_while_empty", 32'(bad_rd), 32'd0);
      repeat (3) step();
      check("idle_after_line", 32'({busy, fifo_rd_en}), 32'd0);
      sb.delete();
   endtask

   row_t rr;

   initial begin
      rows[0] = '{8'hFF, 0,  -1, 0, -1, 1'b0, 1'b0, 0};
      rows[1] = '{8'h80, 10, -1, 0, -1, 1'b0, 1'b0, 0};
      rows[2] = '{8'h40, 0,  5,  3, -1, 1'b1, 1'b0, PAD_MODE ? 0 : 3};
      rows[3] = '{8'h20, 0,  -1, 0, 8,  1'b1, 1'b1, 0};

      rd_rst_n = 1'b0; line_req = 1'b0; fifo_almost_empty = 1'b0;
      rd_cnt = 0; valid_cnt = 0; gap_run = 0; max_gap = 0; bad_rd = 0;
      stall_left = 0; stall_at = 0; stall_len = 0;
      #2;
      check("reset_outputs",
            32'({fifo_rd_en, pix_valid, pix_data, pix_sol, pix_eol, busy, underflow, req_drop}), 32'd0);
      #20 rd_rst_n = 1'b1;
      repeat (5) step();
      check("no_start_without_req", 32'({busy, fifo_rd_en, pix_valid}), 32'd0);

      for (int i = 0; i < 4; i++) run_line(rows[i]);

      // reset in the middle of a line, after pixel 7 has been emitted
      rr = '{8'h10, 0, -1, 0, -1, 1'b0, 1'b0, 0};
      start_line(rr);
      for (int g = 0; g < 60 && valid_cnt < 8; g++) step();
      check("reached_pixel7", 32'(valid_cnt), 32'd8);
      #1 rd_rst_n = 1'b0;
      #1;
      check("midline_reset_outputs",
            32'({fifo_rd_en, pix_valid, pix_data, pix_sol, pix_eol, busy, underflow, req_drop}), 32'd0);
      sb.delete();
      @(posedge clk);
      #2;
      check("reset_held_outputs", 32'({fifo_rd_en, pix_valid, busy}), 32'd0);
      rd_rst_n = 1'b1;
      valid_cnt = 0;
      repeat (4) step();
      check("no_restart_after_reset", 32'({busy, fifo_rd_en, pix_valid}), 32'd0);
      rr = '{8'h60, 0, -1, 0, -1, 1'b0, 1'b0, 0};
      run_line(rr);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
